// File: rtl/data_ram.sv
// Byte-addressable data memory with a request/done handshake, sized and
// misaligned access checks, sign/zero-extended loads and configurable wait states.
module data_ram #(
    parameter int AWIDTH      = 10,
    parameter int DWIDTH      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DWIDTH-1:0] rdata
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int DEPTH  = 2 ** (AWIDTH - LSB);
    // Preloading WAIT_STATES places the access edge WAIT_STATES+1 edges after acceptance.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              unsigned_ld;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] wdata;
    } acc_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       access;
    logic       accept;
    acc_t       cur, held, op;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [LSB-1:0]        lane;
    logic [AWIDTH-LSB-1:0] idx;
    logic                  bad;
    logic [NBYTES-1:0]     be;
    logic [DWIDTH-1:0]     wshift;
    logic [DWIDTH-1:0]     rword, shifted, left, zext;
    logic signed [DWIDTH-1:0] sext;
    logic [6:0]            shamt;

    assign ready  = (state != ST_WAIT);
    assign done   = (state == ST_RESP);
    assign accept = req && ready;

    assign cur = '{we: we, size: size, unsigned_ld: unsigned_ld, addr: addr, wdata: wdata};
    // Zero-wait accesses use the live request; delayed ones use the copy taken at acceptance.
    assign op  = (state == ST_WAIT) ? held : cur;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    access   = 1'b1;
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        access   = 1'b1;
                        state_nx = ST_RESP;
                    end else begin
                        cnt_nx   = CNT_LOAD;
                        state_nx = ST_WAIT;
                    end
                end
            end
        endcase
    end

    assign lane = op.addr[LSB-1:0];
    assign idx  = op.addr[AWIDTH-1:LSB];

    always_comb begin
        case (op.size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = op.addr[0];
            2'd2:    bad = |op.addr[1:0];
            default: bad = (DWIDTH == 32) || (|op.addr[2:0]);
        endcase
    end

    always_comb begin
        be = '0;
        for (int b = 0; b < NBYTES; b++)
            be[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << op.size));
    end

    assign wshift  = op.wdata << {lane, 3'b000};
    assign rword   = mem[idx];
    assign shifted = rword >> {lane, 3'b000};

    // Push the loaded field to the top, then shift back down to extend it.
    always_comb begin
        case (op.size)
            2'd0:    shamt = 7'(DWIDTH - 8);
            2'd1:    shamt = 7'(DWIDTH - 16);
            2'd2:    shamt = 7'(DWIDTH - 32);
            default: shamt = 7'd0;
        endcase
    end

    assign left = shifted << shamt;
    assign zext = left >> shamt;
    assign sext = $signed(left) >>> shamt;

    // NOTE: the array has no reset; contents start undefined and survive rst.
    always_ff @(posedge clk) begin
        if (!rst && access && op.we && !bad) begin
            for (int b = 0; b < NBYTES; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            err   <= 1'b0;
            rdata <= '0;
            held  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept)
                held <= cur;
            if (access) begin
                err   <= bad;
                rdata <= (bad || op.we) ? '0 : (op.unsigned_ld ? zext : DWIDTH'(sext));
            end
        end
    end

endmodule
